// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad emulator: key codes, FSM states and the
// switch-matrix position of every key.
package keypad_pkg;

    localparam logic [3:0] KEY_HASH = 4'd10;
    localparam logic [3:0] KEY_STAR = 4'd11;
    localparam logic [3:0] KEY_A    = 4'd12;
    localparam logic [3:0] KEY_B    = 4'd13;
    localparam logic [3:0] KEY_C    = 4'd14;
    localparam logic [3:0] KEY_D    = 4'd15;

    localparam logic [3:0] ROW_IDLE = 4'b1111;

    typedef enum logic [1:0] {
        StIdle,
        StBounce,
        StHold,
        StGap
    } kp_state_e;

    // Active-low row line driven when the key is closed.
    function automatic logic [3:0] row_of(input logic [3:0] code);
        case (code)
            4'd1, 4'd2, 4'd3, KEY_A:           row_of = 4'b1110;
            4'd4, 4'd5, 4'd6, KEY_B:           row_of = 4'b1101;
            4'd7, 4'd8, 4'd9, KEY_C:           row_of = 4'b1011;
            4'd0, KEY_HASH, KEY_STAR, KEY_D:   row_of = 4'b0111;
            default:                           row_of = ROW_IDLE;
        endcase
    endfunction

    // Index of the (active-low) column strobe that reaches this key.
    function automatic logic [1:0] col_idx(input logic [3:0] code);
        case (code)
            4'd1, 4'd4, 4'd7, KEY_STAR:        col_idx = 2'd0;
            4'd2, 4'd5, 4'd8, 4'd0:            col_idx = 2'd1;
            4'd3, 4'd6, 4'd9, KEY_HASH:        col_idx = 2'd2;
            default:                           col_idx = 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/kp_key_fifo.sv
// Key-code queue between the host and the press sequencer. Full is registered
// so the host-facing ready never depends combinationally on a pop.
module kp_key_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic [3:0] push_data,
    input  logic       pop,
    output logic [3:0] pop_data,
    output logic       full,
    output logic       empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          full_q;
    logic          do_push, do_pop;

    assign do_push = push && !full_q;
    assign do_pop  = pop && (count_q != '0);

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == (AW + 1)'(DEPTH));
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem[rd_ptr_q];
    assign full     = full_q;
    assign empty    = (count_q == '0);

endmodule

// File: rtl/keypad_emulator.sv
// Plays queued key codes into a matrix-keypad scanner: each key bounces,
// holds and releases, answering column strobes the way a real switch would.
module keypad_emulator #(
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned CNT_W         = 24,
    parameter int unsigned BOUNCE_CYCLES = 0,
    parameter int unsigned BOUNCE_PERIOD = 64,
    parameter int unsigned HOLD_CYCLES   = 1000000,
    parameter int unsigned GAP_CYCLES    = 500000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic       pressing,
    output logic       busy,
    output logic       key_done
);

    import keypad_pkg::*;

    localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'(BOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] BOUNCE_DIV  = CNT_W'(BOUNCE_PERIOD);

    kp_state_e        state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [3:0]       cur_key_q, cur_key_d;
    logic [3:0]       row_q;
    logic             pressing_q, contact_d;
    logic             fifo_pop, fifo_full, fifo_empty;
    logic [3:0]       fifo_data;

    assign key_ready = !fifo_full;

    kp_key_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (key_valid && key_ready),
        .push_data (key_code),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + 1'b1;
        cur_key_d = cur_key_q;
        fifo_pop  = 1'b0;
        key_done  = 1'b0;
        case (state_q)
            StIdle: begin
                timer_d = '0;
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    cur_key_d = fifo_data;
                    state_d   = (BOUNCE_CYCLES > 0) ? StBounce : StHold;
                end
            end
            StBounce: begin
                if (timer_q == BOUNCE_LAST) begin
                    state_d = StHold;
                    timer_d = '0;
                end
            end
            StHold: begin
                if (timer_q == HOLD_LAST) begin
                    state_d = StGap;
                    timer_d = '0;
                end
            end
            StGap: begin
                if (timer_q == GAP_LAST) begin
                    state_d  = StIdle;
                    timer_d  = '0;
                    key_done = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                timer_d = '0;
            end
        endcase
    end

    // Contact state is computed for the state being entered so that pressing
    // changes on the same edge as the FSM.
    always_comb begin
        contact_d = 1'b0;
        case (state_d)
            StBounce: contact_d = ((timer_d / BOUNCE_DIV) & CNT_W'(1)) == '0;
            StHold:   contact_d = 1'b1;
            default:  contact_d = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            cur_key_q  <= '0;
            pressing_q <= 1'b0;
            row_q      <= ROW_IDLE;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            cur_key_q  <= cur_key_d;
            pressing_q <= contact_d;
            row_q      <= (pressing_q && !col_in[col_idx(cur_key_q)]) ? row_of(cur_key_q)
                                                                       : ROW_IDLE;
        end
    end

    assign row_out  = row_q;
    assign pressing = pressing_q;
    assign busy     = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: a plain instance and a bouncing instance share
// stimulus and are both compared every cycle against a timeline model.
module tb_keypad_emulator;

    localparam int HOLD = 20;
    localparam int GAP  = 10;
    localparam int BNC  = 8;
    localparam int BPER = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic [3:0] col_in = 4'hF;

    logic [3:0] row_w   [2];
    logic       ready_w [2];
    logic       press_w [2];
    logic       busy_w  [2];
    logic       done_w  [2];

    always #5 clock = ~clock;

    keypad_emulator #(
        .DEPTH(8), .CNT_W(24), .BOUNCE_CYCLES(0), .BOUNCE_PERIOD(64),
        .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)
    ) u_plain (
        .clock(clock), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .key_ready(ready_w[0]), .col_in(col_in), .row_out(row_w[0]),
        .pressing(press_w[0]), .busy(busy_w[0]), .key_done(done_w[0])
    );

    keypad_emulator #(
        .DEPTH(8), .CNT_W(24), .BOUNCE_CYCLES(BNC), .BOUNCE_PERIOD(BPER),
        .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)
    ) u_bounce (
        .clock(clock), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .key_ready(ready_w[1]), .col_in(col_in), .row_out(row_w[1]),
        .pressing(press_w[1]), .busy(busy_w[1]), .key_done(done_w[1])
    );

    int checks = 0;
    int errors = 0;

    // Model: per instance, a list of queued codes and the offset into the
    // current key's press timeline (bounce, hold, gap laid end to end).
    bit         mvalid = 1'b0;
    bit         mact   [2];
    int         mk     [2];
    int         mcur   [2];
    int         mq     [2][16];
    int         mqn    [2];
    bit         mready [2];
    logic [3:0] mrow   [2];

    function automatic int pb(int i);
        return (i == 0) ? 0 : BNC;
    endfunction

    function automatic int pp(int i);
        return (i == 0) ? 64 : BPER;
    endfunction

    function automatic int total(int i);
        return pb(i) + HOLD + GAP;
    endfunction

    function automatic bit m_closed(int i, int k);
        if (k < pb(i)) return ((k / pp(i)) % 2) == 0;
        return k < pb(i) + HOLD;
    endfunction

    function automatic logic [3:0] m_row(int c);
        int r;
        if (c >= 1 && c <= 9) r = (c - 1) / 3;
        else if (c == 0 || c == 10 || c == 11) r = 3;
        else r = c - 12;
        return ~(4'b0001 << r);
    endfunction

    function automatic int m_col(int c);
        if (c >= 1 && c <= 9) return (c - 1) % 3;
        if (c == 0) return 1;
        if (c == 10) return 2;
        if (c == 11) return 0;
        return 3;
    endfunction

    function automatic logic [3:0] rot_col(int t);
        return ~(4'b0001 << (t % 4));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit ep;
        if (!mvalid) return;
        for (int i = 0; i < 2; i++) begin
            ep = mact[i] && m_closed(i, mk[i]);
            chk($sformatf("row_out%0d", i), 32'(row_w[i]), 32'(mrow[i]));
            chk($sformatf("pressing%0d", i), 32'(press_w[i]), 32'(ep));
            chk($sformatf("key_ready%0d", i), 32'(ready_w[i]), 32'(mready[i]));
            chk($sformatf("busy%0d", i), 32'(busy_w[i]), 32'(mact[i] || mqn[i] > 0));
            chk($sformatf("key_done%0d", i), 32'(done_w[i]),
                32'(mact[i] && mk[i] == total(i) - 1));
        end
    endtask

    task automatic model_edge();
        bit         pr;
        logic [3:0] nrow;
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                mqn[i] = 0;
                mact[i] = 1'b0;
                mready[i] = 1'b1;
                mrow[i] = 4'hF;
            end
            mvalid = 1'b1;
            return;
        end
        if (!mvalid) return;
        for (int i = 0; i < 2; i++) begin
            pr = mact[i] && m_closed(i, mk[i]);
            nrow = (pr && col_in[m_col(mcur[i])] == 1'b0) ? m_row(mcur[i]) : 4'hF;
            if (mact[i]) begin
                mk[i]++;
                if (mk[i] == total(i)) mact[i] = 1'b0;
            end else if (mqn[i] > 0) begin
                mcur[i] = mq[i][0];
                for (int j = 0; j < 15; j++) mq[i][j] = mq[i][j+1];
                mqn[i]--;
                mact[i] = 1'b1;
                mk[i] = 0;
            end
            if (key_valid && mready[i]) begin
                mq[i][mqn[i]] = int'(key_code);
                mqn[i]++;
            end
            mready[i] = mqn[i] < 8;
            mrow[i] = nrow;
        end
    endtask

    task automatic cycle();
        check_all();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input int code);
        key_valid = 1'b1;
        key_code = 4'(code);
        cycle();
        key_valid = 1'b0;
    endtask

    task automatic drain(input int maxc, input bit rot, output int dones);
        dones = 0;
        for (int t = 0; t < maxc && (busy_w[0] || busy_w[1]); t++) begin
            col_in = rot ? rot_col(t) : 4'($urandom_range(0, 15));
            cycle();
            if (done_w[0]) dones++;
        end
        chk("drain_idle", 32'({busy_w[0], busy_w[1]}), 32'(0));
    endtask

    initial begin
        int         d, np, nd, fp, kd, bz, val;
        int         dec[$];
        logic [3:0] obs[40];
        logic [3:0] r;

        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        chk("rst_row", 32'(row_w[0]), 32'hF);
        chk("rst_pressing", 32'(press_w[0]), 32'(0));
        chk("rst_busy", 32'(busy_w[0]), 32'(0));
        chk("rst_done", 32'(done_w[0]), 32'(0));
        chk("rst_ready", 32'(ready_w[1]), 32'(1));

        // Map sweep with rotating column strobes.
        for (int c = 0; c < 16; c++) begin
            push(c);
            drain(100, 1'b1, d);
            chk($sformatf("sweep_done%0d", c), 32'(d), 32'(1));
        end

        col_in = 4'b1101;
        push(5);
        for (int t = 0; t < 5; t++) cycle();
        chk("key5_row", 32'(row_w[0]), 32'(4'b1101));
        drain(100, 1'b0, d);

        // Press timing on the non-bouncing instance.
        push(1);
        np = 0; nd = 0; fp = -1; kd = -10; bz = -1;
        for (int t = 0; t < 60; t++) begin
            col_in = 4'($urandom_range(0, 15));
            cycle();
            if (t == kd + 1) bz = int'(busy_w[0]);
            if (press_w[0]) begin
                np++;
                if (fp < 0) fp = t;
            end
            if (done_w[0]) begin
                nd++;
                kd = t;
            end
        end
        chk("hold_cycles", 32'(np), 32'(HOLD));
        chk("done_count", 32'(nd), 32'(1));
        chk("done_offset", 32'(kd - fp), 32'(HOLD + GAP - 1));
        chk("busy_after_done", 32'(bz), 32'(0));
        drain(60, 1'b0, d);

        // Queue "1234#" and decode it with a scanner model.
        key_valid = 1'b1;
        for (int j = 0; j < 5; j++) begin
            key_code = (j == 4) ? 4'd10 : 4'(j + 1);
            cycle();
        end
        key_valid = 1'b0;
        for (int t = 0; t < 400 && (busy_w[0] || busy_w[1]); t++) begin
            col_in = rot_col(t);
            cycle();
            r = row_w[0];
            if (r != 4'hF) begin
                for (int c = 0; c < 16; c++) begin
                    if (m_row(c) == r && m_col(c) == t % 4) begin
                        if (dec.size() == 0 || dec[dec.size()-1] != c) dec.push_back(c);
                    end
                end
            end
        end
        chk("scan_idle", 32'({busy_w[0], busy_w[1]}), 32'(0));
        chk("scan_count", 32'(dec.size()), 32'(5));
        val = -1;
        if (dec.size() == 5 && dec[4] == 10)
            val = dec[0] * 1000 + dec[1] * 100 + dec[2] * 10 + dec[3];
        chk("scan_value", 32'(val), 32'(1234));

        // Fill the queue while the first key is being held.
        push(7);
        cycle();
        cycle();
        key_valid = 1'b1;
        for (int j = 0; j < 9; j++) begin
            key_code = 4'(j + 1);
            cycle();
            if (j == 6) chk("prefull_ready", 32'(ready_w[0]), 32'(1));
            if (j == 7) chk("full_ready", 32'(ready_w[0]), 32'(0));
        end
        key_valid = 1'b0;
        drain(500, 1'b0, d);
        chk("full_dones", 32'(d), 32'(9));

        // Bounce pattern seen on the row lines with the key's column held low.
        col_in = 4'b1011;
        push(6);
        for (int t = 0; t < 40; t++) begin
            cycle();
            obs[t] = row_w[1];
        end
        chk("bounce_pre", 32'(obs[0]), 32'hF);
        for (int j = 0; j < 29; j++) begin
            if (j < 8)
                chk($sformatf("bounce_row%0d", j), 32'(obs[1+j]),
                    ((j / 2) % 2 == 0) ? 32'(4'b1101) : 32'hF);
            else if (j < 28)
                chk($sformatf("hold_row%0d", j), 32'(obs[1+j]), 32'(4'b1101));
            else
                chk("release_row", 32'(obs[1+j]), 32'hF);
        end
        drain(100, 1'b0, d);

        // Reset in the middle of a hold.
        col_in = 4'b1101;
        push(2);
        for (int t = 0; t < 10; t++) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("midrst_row", 32'(row_w[0]), 32'hF);
        chk("midrst_pressing", 32'(press_w[0]), 32'(0));
        chk("midrst_busy", 32'({busy_w[0], busy_w[1]}), 32'(0));
        chk("midrst_ready", 32'(ready_w[0]), 32'(1));
        nd = 0;
        for (int t = 0; t < 50; t++) begin
            cycle();
            if (done_w[0] || done_w[1]) nd++;
        end
        chk("midrst_no_done", 32'(nd), 32'(0));

        // Random traffic with occasional resets.
        for (int t = 0; t < 800; t++) begin
            key_valid = ($urandom_range(0, 3) == 0);
            key_code = 4'($urandom_range(0, 15));
            col_in = 4'($urandom_range(0, 15));
            reset = ($urandom_range(0, 249) == 0);
            cycle();
        end
        reset = 1'b0;
        key_valid = 1'b0;
        drain(600, 1'b0, d);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
